// File: rtl/reg_bank_rd_pkg.sv
// reg_bank_rd_pkg: constants and types shared by the register bank and its
// response queue. The queue depth is fixed at two, which is the smallest
// depth that keeps full read throughput with a registered req_rdy.
package reg_bank_rd_pkg;

  localparam int RESP_DEPTH = 2;

  // Occupancy of the response queue, 0..RESP_DEPTH
  typedef logic [1:0] count_t;

  // Address width for a bank of nregs entries (at least one bit)
  function automatic int addr_width(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/reg_bank_rd_queue.sv
// reg_bank_rd_queue: two-entry FIFO with val/rdy on both sides.
// enq_rdy_o depends only on registered occupancy, so there is no
// combinational path from the dequeue side back to the enqueue side.
module reg_bank_rd_queue
  import reg_bank_rd_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_val_i,
  output logic             enq_rdy_o,
  input  logic [NBITS-1:0] enq_data_i,
  output logic             deq_val_o,
  input  logic             deq_rdy_i,
  output logic [NBITS-1:0] deq_data_o
);

  logic [NBITS-1:0] entries_q [RESP_DEPTH];
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  count_t           count_q, count_d;
  logic             enqFire, deqFire;

  assign enq_rdy_o  = (count_q < count_t'(RESP_DEPTH));
  assign deq_val_o  = (count_q != count_t'(0));
  assign deq_data_o = entries_q[head_q];
  assign enqFire    = enq_val_i && enq_rdy_o;
  assign deqFire    = deq_val_o && deq_rdy_i;

  // Next-state for the ring pointers and occupancy
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enqFire) tail_d = ~tail_q;
    if (deqFire) head_d = ~head_q;
    if (enqFire && !deqFire) count_d = count_q + count_t'(1);
    if (deqFire && !enqFire) count_d = count_q - count_t'(1);
  end

  // Pointer/count registers; reset empties the queue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; cleared on reset so the head reads zero out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RESP_DEPTH; i++) entries_q[i] <= '0;
    end else if (enqFire) begin
      entries_q[tail_q] <= enq_data_i;
    end
  end

endmodule

// File: rtl/reg_bank_rd.sv
// reg_bank_rd: register bank with a plain write-enable write port and a
// val/rdy read port answered through a two-entry response queue.
// Build option REG_BANK_RD_BYPASS_EN: when defined, a read accepted on the
// same edge as a write to the same address returns the newly written data;
// otherwise it returns the value held before the write.
module reg_bank_rd
  import reg_bank_rd_pkg::*;
#(
  parameter  int NBITS = 32,
  parameter  int NREGS = 8,
  localparam int AW    = addr_width(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w,
  input  logic [AW-1:0]    waddr,
  input  logic [NBITS-1:0] d,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [AW-1:0]    req_addr,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [NBITS-1:0] resp_data
);

  logic [NBITS-1:0] regs_q [NREGS];
  logic [NBITS-1:0] rdData;

  // Storage array; all entries return to zero on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (w) begin
      regs_q[waddr] <= d;
    end
  end

  // Read data captured into the queue on request acceptance
  always_comb begin
    rdData = regs_q[req_addr];
`ifdef REG_BANK_RD_BYPASS_EN
    if (w && (waddr == req_addr)) rdData = d;
`endif
  end

  reg_bank_rd_queue #(
    .NBITS(NBITS)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .enq_val_i  (req_val),
    .enq_rdy_o  (req_rdy),
    .enq_data_i (rdData),
    .deq_val_o  (resp_val),
    .deq_rdy_i  (resp_rdy),
    .deq_data_o (resp_data)
  );

endmodule

// File: tb/tb_reg_bank_rd.sv
// tb_reg_bank_rd: self-checking bench for reg_bank_rd. A small model of the
// bank contents and queue occupancy predicts req_rdy/resp_val every cycle;
// read data expected at acceptance is queued and compared at dequeue.
module tb_reg_bank_rd;

  logic        clk = 1'b0;
  logic        reset;
  logic        w;
  logic [2:0]  waddr;
  logic [31:0] d;
  logic        req_val;
  logic        req_rdy;
  logic [2:0]  req_addr;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_data;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] memModel [8];
  logic [31:0] sb [$];
  int          cntModel = 0;

  typedef struct {
    bit          w;
    logic [2:0]  waddr;
    logic [31:0] d;
    bit          rv;
    logic [2:0]  ra;
    bit          rr;
    int          expRdy;
    int          expVal;
  } vec_t;

  vec_t tbl [10];

  reg_bank_rd #(.NBITS(32), .NREGS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .w         (w),
    .waddr     (waddr),
    .d         (d),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_addr  (req_addr),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_data (resp_data)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs at the negedge, update the model
  task automatic applyStimulus(input bit iw, input logic [2:0] iwa, input logic [31:0] id,
                               input bit rv, input logic [2:0] ra, input bit rr,
                               input int expRdy = -1, input int expVal = -1);
    logic [31:0] exp;
    bit enq, deq;
    w = iw; waddr = iwa; d = id;
    req_val = rv; req_addr = ra; resp_rdy = rr;
    @(negedge clk);
    checkOutput("req_rdy", 32'(req_rdy), 32'(cntModel < 2));
    checkOutput("resp_val", 32'(resp_val), 32'(cntModel > 0));
    if (expRdy >= 0) checkOutput("tbl_req_rdy", 32'(req_rdy), 32'(expRdy));
    if (expVal >= 0) checkOutput("tbl_resp_val", 32'(resp_val), 32'(expVal));
    deq = (cntModel > 0) && rr;
    enq = rv && (cntModel < 2);
    if (deq) begin
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        checkOutput("resp_data", resp_data, exp);
      end else begin
        checks++;
        failures++;
        $display("[TB] FAIL scoreboard_empty: got response %h expected none", resp_data);
      end
    end
    if (enq) begin
      exp = memModel[ra];
`ifdef REG_BANK_RD_BYPASS_EN
      if (iw && (iwa == ra)) exp = id;
`endif
      sb.push_back(exp);
    end
    if (iw) memModel[iwa] = id;
    cntModel = cntModel + (enq ? 1 : 0) - (deq ? 1 : 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && cntModel > 0; k++) applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("drained_count", 32'(cntModel), 32'd0);
  endtask

  // Main test sequence
  initial begin
    // Backpressure vectors: prefill, two accepted, third stalls, then drain in order
    tbl[0] = '{1, 3'd0, 32'h11, 0, 3'd0, 0, 1, 0};
    tbl[1] = '{1, 3'd1, 32'h22, 0, 3'd0, 0, 1, 0};
    tbl[2] = '{1, 3'd2, 32'h33, 0, 3'd0, 0, 1, 0};
    tbl[3] = '{0, 3'd0, 32'h0,  1, 3'd0, 0, 1, 0};
    tbl[4] = '{0, 3'd0, 32'h0,  1, 3'd1, 0, 1, 1};
    tbl[5] = '{0, 3'd0, 32'h0,  1, 3'd2, 0, 0, 1};
    tbl[6] = '{0, 3'd0, 32'h0,  1, 3'd2, 1, 0, 1};
    tbl[7] = '{0, 3'd0, 32'h0,  1, 3'd2, 1, 1, 1};
    tbl[8] = '{0, 3'd0, 32'h0,  0, 3'd0, 1, 1, 1};
    tbl[9] = '{0, 3'd0, 32'h0,  0, 3'd0, 1, 1, 0};

    for (int i = 0; i < 8; i++) memModel[i] = '0;
    w = 0; waddr = 0; d = 0; req_val = 0; req_addr = 0; resp_rdy = 0;
    reset = 1'b1;
    #1;
    checkOutput("reset_req_rdy", 32'(req_rdy), 32'd1);
    checkOutput("reset_resp_val", 32'(resp_val), 32'd0);
    checkOutput("reset_resp_data", resp_data, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // All entries read back zero after reset
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 1, 3'(i), 1);
    drain();

    // Write then read on the following cycle
    applyStimulus(1, 3'd3, 32'hDEADBEEF, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 3'd3, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 1);
    drain();

    // Backpressure table
    for (int i = 0; i < 10; i++)
      applyStimulus(tbl[i].w, tbl[i].waddr, tbl[i].d, tbl[i].rv, tbl[i].ra, tbl[i].rr,
                    tbl[i].expRdy, tbl[i].expVal);
    drain();

    // Same-edge write and read of one address
    applyStimulus(1, 3'd5, 32'h5, 0, 0, 1);
    applyStimulus(1, 3'd5, 32'hAAAA5555, 1, 3'd5, 1);
    drain();
    applyStimulus(0, 0, 0, 1, 3'd5, 1);
    drain();

    // Streaming: 16 back-to-back requests with the consumer always ready
    for (int i = 0; i < 8; i++) applyStimulus(1, 3'(i), 32'h0100_0000 + 32'(i * 32'h0101), 0, 0, 1);
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 1, 3'(i % 8), 1);
    drain();

    // Reset with the queue full
    applyStimulus(0, 0, 0, 1, 3'd1, 0);
    applyStimulus(0, 0, 0, 1, 3'd2, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    req_val = 0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset_resp_val", 32'(resp_val), 32'd0);
    checkOutput("midreset_req_rdy", 32'(req_rdy), 32'd1);
    checkOutput("midreset_resp_data", resp_data, 32'h0);
    sb.delete();
    cntModel = 0;
    for (int i = 0; i < 8; i++) memModel[i] = '0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 1, 3'(i), 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
